// File: rtl/fwd_pkg.sv
// Shared sizing helpers and constants for the operand forwarding unit.
package fwd_pkg;

  localparam int SEL_RF = 0;

  function automatic int sel_w(input int num_src);
    return $clog2(num_src + 1);
  endfunction

  function automatic int idx_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  // Low bit of slice idx inside a packed bus of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/fwd_prio_match.sv
// Combinational destination match of rs_addr against all forwarding sources.
// Lowest-index hit wins; the zero register never matches when ZERO_REG is set.
module fwd_prio_match
  import fwd_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 4,
  parameter int ZERO_REG = 1
) (
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_wen,
  input  logic [ADDR_W-1:0]         rs_addr,
  output logic                      zero_rd,
  output logic                      hit_any,
  output logic [NUM_SRC-1:0]        win_onehot,
  output logic [idx_w(NUM_SRC)-1:0] win_idx
);

  localparam int IDX_W = idx_w(NUM_SRC);

  logic [NUM_SRC-1:0] hit;

  assign zero_rd = (ZERO_REG != 0) && (rs_addr == '0);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit[i] = src_wen[i] && (src_addr[slice_lo(i, ADDR_W) +: ADDR_W] == rs_addr) && !zero_rd;
    end
  end

  // Isolate the lowest set bit: youngest source has priority.
  assign win_onehot = hit & (~hit + NUM_SRC'(1));
  assign hit_any    = |hit;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_onehot[i]) win_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/fwd_operand_unit.sv
// Resolves one source operand from in-flight results or the register file, 1-cycle latency.
// Single-entry output register; stalls on a pending load and holds output under backpressure.
module fwd_operand_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int NUM_SRC     = 4,
  parameter int ZERO_REG    = 1,
  parameter int STALL_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_wen,
  input  logic [NUM_SRC-1:0]        src_rdy,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [ADDR_W-1:0]         rs_addr,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [sel_w(NUM_SRC)-1:0] out_sel,
  output logic                      stall,
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  localparam int SEL_W = sel_w(NUM_SRC);
  localparam int IDX_W = idx_w(NUM_SRC);

  logic               zero_rd;
  logic               hit_any;
  logic [NUM_SRC-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               pending;
  logic               accept;
  logic [DATA_W-1:0]  fwd_data;
  logic [DATA_W-1:0]  next_data;
  logic [SEL_W-1:0]   next_sel;

  fwd_prio_match #(
    .ADDR_W   (ADDR_W),
    .NUM_SRC  (NUM_SRC),
    .ZERO_REG (ZERO_REG)
  ) u_match (
    .src_addr   (src_addr),
    .src_wen    (src_wen),
    .rs_addr    (rs_addr),
    .zero_rd    (zero_rd),
    .hit_any    (hit_any),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  // AND-OR mux on the one-hot winner keeps unused slices from leaking into the result.
  always_comb begin
    fwd_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_data = fwd_data | (src_data[slice_lo(i, DATA_W) +: DATA_W] & {DATA_W{win_onehot[i]}});
    end
  end

  assign pending   = hit_any && ((win_onehot & src_rdy) == '0);
  assign stall     = req_valid && pending;
  assign req_ready = rst_n && !pending && (!out_valid || out_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    next_data = rf_data;
    next_sel  = SEL_W'(SEL_RF);
    if (hit_any) begin
      next_data = fwd_data;
      next_sel  = SEL_W'(win_idx) + SEL_W'(1);
    end else if (zero_rd) begin
      next_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= next_data;
      out_sel   <= next_sel;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_operand_unit.sv
// Scoreboard bench: stimulus pushes expected operands, a negedge monitor pops and compares.
module tb_fwd_operand_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 4;
  localparam int CW = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [NS*DW-1:0]   src_data;
  logic [NS*AW-1:0]   src_addr;
  logic [NS-1:0]      src_wen;
  logic [NS-1:0]      src_rdy;
  logic [DW-1:0]      rf_data;
  logic [AW-1:0]      rs_addr;
  logic               req_valid;
  logic               req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [SW-1:0]      out_sel;
  logic               stall;
  logic [CW-1:0]      stall_cnt;

  fwd_operand_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_data  (src_data),
    .src_addr  (src_addr),
    .src_wen   (src_wen),
    .src_rdy   (src_rdy),
    .rf_data   (rf_data),
    .rs_addr   (rs_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    bit             rst;
    bit             rv;
    bit             ordy;
    logic [NS*DW-1:0] data;
    logic [NS*AW-1:0] addr;
    logic [NS-1:0]  wen;
    logic [NS-1:0]  rdy;
    logic [DW-1:0]  rf;
    logic [AW-1:0]  rs;
  } stim_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   started = 0;

  bit m_ov = 0, m_ov_n = 0;
  int m_cnt = 0, m_cnt_n = 0;
  bit chk_zero = 0, zero_n = 0;
  bit exp_ready = 0, exp_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.rv = 0; s.ordy = 1;
    s.data = '0; s.addr = '0; s.wen = '0; s.rdy = '1;
    s.rf = '0; s.rs = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst  = ($urandom_range(0, 499) == 0);
    s.rv   = ($urandom_range(0, 3) != 0);
    s.ordy = ($urandom_range(0, 9) < 7);
    s.data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NS; i++) begin
      s.addr[i*AW +: AW] = AW'($urandom_range(0, 3));
      s.rdy[i] = ($urandom_range(0, 3) != 0);
    end
    s.wen = NS'($urandom);
    s.rf  = $urandom;
    s.rs  = AW'($urandom_range(0, 3));
    return s;
  endfunction

  // One cycle: apply inputs after the edge, then evaluate the reference rules.
  task automatic step(input stim_t s);
    int   win;
    bit   pend;
    exp_t e;
    @(posedge clk);
    #1;
    m_ov = m_ov_n; m_cnt = m_cnt_n; chk_zero = zero_n;
    rst_n = !s.rst; req_valid = s.rv; out_ready = s.ordy;
    src_data = s.data; src_addr = s.addr; src_wen = s.wen; src_rdy = s.rdy;
    rf_data = s.rf; rs_addr = s.rs;
    #1;
    win = -1;
    if (s.rs != 0) begin
      for (int i = NS - 1; i >= 0; i--)
        if (s.wen[i] && s.addr[i*AW +: AW] == s.rs) win = i;
    end
    pend = (win >= 0) && !s.rdy[win];
    exp_stall = s.rv && pend;
    exp_ready = !s.rst && !pend && (!m_ov || s.ordy);
    if (win >= 0) begin
      e.d = s.data[win*DW +: DW];
      e.s = SW'(win + 1);
    end else begin
      e.d = (s.rs == 0) ? '0 : s.rf;
      e.s = '0;
    end
    if (s.rst) begin
      m_ov_n = 0; m_cnt_n = 0; zero_n = 1;
      sb_q.delete();
    end else begin
      zero_n = 0;
      if (s.rv && exp_ready) begin
        sb_q.push_back(e);
        m_ov_n = 1;
      end else if (m_ov && s.ordy) begin
        m_ov_n = 0;
      end else begin
        m_ov_n = m_ov;
      end
      m_cnt_n = (exp_stall && m_cnt < 255) ? m_cnt + 1 : m_cnt;
    end
    started = 1;
  endtask

  initial begin : monitor
    exp_t f;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        if (rst_n) begin
          chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
          chk("stall_cnt", {24'b0, stall_cnt}, m_cnt);
          if (chk_zero) begin
            chk("rst_out_data", out_data, 32'h0);
            chk("rst_out_sel", {29'b0, out_sel}, 32'h0);
          end
          if (out_valid) begin
            if (sb_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL sb_underflow: got out_data %h with no expected entry at %0t", out_data, $time);
            end else begin
              f = sb_q[0];
              chk("out_data", out_data, f.d);
              chk("out_sel", {29'b0, out_sel}, {29'b0, f.s});
              if (out_ready) void'(sb_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin : driver
    stim_t s;
    rst_n = 0; req_valid = 0; out_ready = 0; src_data = '0; src_addr = '0;
    src_wen = '0; src_rdy = '1; rf_data = '0; rs_addr = '0;

    s = idle(); s.rst = 1; step(s); step(s);

    // no hit: register file
    s = idle(); s.rs = 3; s.rf = 32'hAAAA_0001; s.rv = 1; step(s);
    s.rv = 0; step(s);

    // priority between two hits, then only the older one
    s = idle(); s.addr = {5'd1, 5'd7, 5'd2, 5'd7};
    s.data = {32'h44, 32'h33, 32'h22, 32'h11};
    s.wen = 4'b0101; s.rs = 7; s.rv = 1; step(s);
    s.wen = 4'b0100; step(s);
    s.rv = 0; step(s);

    // load-use on source 1 for three cycles
    s = idle(); s.addr = {5'd9, 5'd9, 5'd5, 5'd9}; s.wen = 4'b0010;
    s.rdy = 4'b1101; s.data[63:32] = 32'hBEEF_0005; s.rs = 5; s.rv = 1;
    repeat (3) step(s);
    s.rdy = 4'b1111; step(s);
    s.rv = 0; step(s);

    // zero register never forwarded and never stalls
    s = idle(); s.wen = 4'b0001; s.data[31:0] = 32'hFF; s.rf = 32'h5;
    s.rdy = 4'b1110; s.rs = 0; s.rv = 1; step(s);
    s.rv = 0; step(s);

    // backpressure then full throughput
    s = idle(); s.rv = 1; s.ordy = 0; s.rs = 4;
    for (int i = 0; i < 2; i++) begin s.rf = 32'h1000 + i; step(s); end
    s.ordy = 1;
    for (int i = 2; i < 7; i++) begin s.rf = 32'h1000 + i; step(s); end
    s.rv = 0; step(s); step(s);

    // reset with a held output and a nonzero stall count
    s = idle(); s.addr = {5'd9, 5'd9, 5'd5, 5'd9}; s.wen = 4'b0010;
    s.rdy = 4'b1101; s.data[63:32] = 32'hCAFE_0009; s.rs = 5; s.rv = 1;
    repeat (6) step(s);
    s.rdy = 4'b1111; s.ordy = 0; step(s);
    s.rv = 0; step(s);
    s.rst = 1; step(s);
    s.rst = 0; step(s);

    // saturation of the stall counter
    s.rdy = 4'b1101; s.rv = 1; s.ordy = 1;
    repeat (300) step(s);
    s.rdy = 4'b1111; s.rv = 0; step(s);

    repeat (3000) step(rand_stim());

    s = idle(); repeat (4) step(s);
    @(negedge clk); #1;
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
